// File: rtl/lut_load_if.sv
// Command, word-stream and GPIO-bus signals between the LUT loader host and lut_load_ctrl.
// The master side is the host/loader; the slave side is the controller.
interface lut_load_if;
    logic        cfg_start;
    logic [15:0] cfg_base;
    logic [16:0] cfg_count;
    logic        cfg_abort;
    logic [15:0] word_in;
    logic        word_valid;
    logic        word_ready;
    logic [31:0] gpio_out;
    logic        busy;
    logic        lut_locked;
    logic        done;
    logic        aborted;
    logic [16:0] words_written;

    modport master (
        output cfg_start, cfg_base, cfg_count, cfg_abort, word_in, word_valid,
        input  word_ready, gpio_out, busy, lut_locked, done, aborted, words_written
    );

    modport slave (
        input  cfg_start, cfg_base, cfg_count, cfg_abort, word_in, word_valid,
        output word_ready, gpio_out, busy, lut_locked, done, aborted, words_written
    );
endinterface

// File: rtl/lut_load_ctrl.sv
// Loads a GPIO-programmed lookup table from a valid/ready stream of 16-bit words:
// two address-byte writes, then two data-byte writes per word, relying on table auto-increment.
module lut_load_ctrl #(
    parameter logic [7:0] ADDR_REG     = 8'd0,
    parameter logic [7:0] DATA_REG     = 8'd1,
    parameter logic [7:0] IDLE_ADDR    = 8'd255,
    parameter int         PULSE_CYCLES = 4,
    parameter int         W_CLK_BIT    = 31,
    parameter int         ADDR_LSB     = 16,
    parameter int         DATA_LSB     = 0
) (
    input  logic        clk,
    input  logic        rst,
    lut_load_if.slave   bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_A_HI  = 3'd1;
    localparam logic [2:0] S_A_LO  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_D_HI  = 3'd4;
    localparam logic [2:0] S_D_LO  = 3'd5;
    localparam logic [2:0] S_TRAIL = 3'd6;
    localparam logic [2:0] S_DONE  = 3'd7;

    localparam logic [7:0] CYC_LAST = 8'(PULSE_CYCLES - 1);

    function automatic logic [31:0] make_gpio(input logic [7:0] addr,
                                              input logic [7:0] data,
                                              input logic       strobe);
        logic [31:0] g;
        g                 = 32'd0;
        g[ADDR_LSB +: 8]  = addr;
        g[DATA_LSB +: 8]  = data;
        g[W_CLK_BIT]      = strobe;
        return g;
    endfunction

    localparam logic [31:0] GPIO_IDLE = make_gpio(IDLE_ADDR, 8'd0, 1'b0);

    logic [2:0]  state_q,   state_d;
    logic        phase_q,   phase_d;     // 0: setup, 1: strobe high
    logic [7:0]  cyc_q,     cyc_d;
    logic [15:0] base_q,    base_d;
    logic [16:0] count_q,   count_d;
    logic [15:0] word_q,    word_d;
    logic [16:0] ww_q,      ww_d;
    logic        abort_q,   abort_d;
    logic [31:0] gpio_q,    gpio_d;
    logic        ready_q,   ready_d;
    logic        busy_q,    busy_d;
    logic        done_q,    done_d;
    logic        aborted_q, aborted_d;

    logic        cyc_last_s;
    logic        abort_now_s;
    logic [16:0] ww_inc_s;
    logic [31:0] gpio_hold_s;

    assign cyc_last_s  = (cyc_q == CYC_LAST);
    assign abort_now_s = abort_q | bus.cfg_abort;
    assign ww_inc_s    = ww_q + 17'd1;

    // Sequencer: phase timing, byte selection and word handshake.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cyc_d   = cyc_q;
        base_d  = base_q;
        count_d = count_q;
        word_d  = word_q;
        ww_d    = ww_q;

        if ((state_q != S_IDLE) && bus.cfg_abort) begin
            abort_d = 1'b1;
        end else begin
            abort_d = abort_q;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.cfg_start) begin
                    base_d  = bus.cfg_base;
                    count_d = bus.cfg_count;
                    ww_d    = 17'd0;
                    abort_d = 1'b0;
                    phase_d = 1'b0;
                    cyc_d   = 8'd0;
                    state_d = (bus.cfg_count == 17'd0) ? S_DONE : S_A_HI;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_A_HI, S_A_LO, S_D_HI, S_D_LO: begin
                if (!cyc_last_s) begin
                    cyc_d = cyc_q + 8'd1;
                end else if (!phase_q) begin
                    cyc_d   = 8'd0;
                    phase_d = 1'b1;
                end else begin
                    cyc_d   = 8'd0;
                    phase_d = 1'b0;
                    // An abort never splits a data byte pair: D_HI always goes on to D_LO.
                    case (state_q)
                        S_A_HI:  state_d = abort_now_s ? S_TRAIL : S_A_LO;
                        S_A_LO:  state_d = abort_now_s ? S_TRAIL : S_WAIT;
                        S_D_HI:  state_d = S_D_LO;
                        S_D_LO: begin
                            ww_d    = ww_inc_s;
                            state_d = ((ww_inc_s == count_q) || abort_now_s) ? S_TRAIL : S_WAIT;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end

            S_WAIT: begin
                cyc_d   = 8'd0;
                phase_d = 1'b0;
                if (abort_now_s) begin
                    state_d = S_TRAIL;
                end else if (bus.word_valid) begin
                    word_d  = bus.word_in;
                    state_d = S_D_HI;
                end else begin
                    state_d = S_WAIT;
                end
            end

            S_TRAIL: begin
                if (!cyc_last_s) begin
                    cyc_d = cyc_q + 8'd1;
                end else begin
                    cyc_d   = 8'd0;
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output values for the next cycle, derived from the next state so they line up with it.
    always_comb begin
        gpio_hold_s              = gpio_q;
        gpio_hold_s[W_CLK_BIT]   = 1'b0;

        case (state_d)
            S_IDLE:  gpio_d = GPIO_IDLE;
            S_A_HI:  gpio_d = make_gpio(ADDR_REG, base_d[15:8], phase_d);
            S_A_LO:  gpio_d = make_gpio(ADDR_REG, base_d[7:0],  phase_d);
            S_D_HI:  gpio_d = make_gpio(DATA_REG, word_d[15:8], phase_d);
            S_D_LO:  gpio_d = make_gpio(DATA_REG, word_d[7:0],  phase_d);
            default: gpio_d = gpio_hold_s;
        endcase

        ready_d   = (state_d == S_WAIT);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_q == S_DONE);
        // Aborted means the command ended short of its word count.
        aborted_d = (state_q == S_DONE) && abort_q && (ww_q != count_q);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            phase_q   <= 1'b0;
            cyc_q     <= 8'd0;
            base_q    <= 16'd0;
            count_q   <= 17'd0;
            word_q    <= 16'd0;
            ww_q      <= 17'd0;
            abort_q   <= 1'b0;
            gpio_q    <= GPIO_IDLE;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            cyc_q     <= cyc_d;
            base_q    <= base_d;
            count_q   <= count_d;
            word_q    <= word_d;
            ww_q      <= ww_d;
            abort_q   <= abort_d;
            gpio_q    <= gpio_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign bus.gpio_out      = gpio_q;
    assign bus.word_ready    = ready_q;
    assign bus.busy          = busy_q;
    assign bus.lut_locked    = busy_q;
    assign bus.done          = done_q;
    assign bus.aborted       = aborted_q;
    assign bus.words_written = ww_q;

endmodule

// File: tb/tb_lut_load_ctrl.sv
// Testbench for lut_load_ctrl: a bus monitor plus a GPIO table model check every load
// against the expected strobe sequence and table contents.
module tb_lut_load_ctrl;
    localparam int         P        = 2;
    localparam logic [7:0] T_ADDR   = 8'd0;
    localparam logic [7:0] T_DATA   = 8'd1;
    localparam logic [31:0] IDLE_G  = 32'h00FF_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lut_load_if lif();
    lut_load_ctrl #(.PULSE_CYCLES(P)) dut (.clk(clk), .rst(rst), .bus(lif));

    int n_checks = 0;
    int n_fail   = 0;

    // Bus monitor and table model
    logic [31:0] prev_g;
    int          hi_len, n_strobes, bad_width, field_chg, lock_bad;
    logic [15:0] mon_q[$];
    logic [15:0] tab[int];
    logic [15:0] t_addr;
    logic [7:0]  t_ahi, t_dhi;
    bit          t_aph, t_dph;

    function void table_write(input logic [7:0] a, input logic [7:0] d);
        if (a == T_ADDR) begin
            if (!t_aph) begin t_ahi = d; t_aph = 1'b1; end
            else begin t_addr = {t_ahi, d}; t_aph = 1'b0; end
        end else if (a == T_DATA) begin
            if (!t_dph) begin t_dhi = d; t_dph = 1'b1; end
            else begin tab[int'(t_addr)] = {t_dhi, d}; t_addr = t_addr + 16'd1; t_dph = 1'b0; end
        end
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            prev_g = lif.gpio_out;
            hi_len = 0;
        end else begin
            if (lif.busy !== lif.lut_locked) lock_bad++;
            if (lif.gpio_out[31] && prev_g[31] && (lif.gpio_out[30:0] != prev_g[30:0])) field_chg++;
            if (lif.gpio_out[31] && !prev_g[31]) begin
                mon_q.push_back({lif.gpio_out[23:16], lif.gpio_out[7:0]});
                n_strobes++;
                table_write(lif.gpio_out[23:16], lif.gpio_out[7:0]);
                hi_len = 1;
            end else if (lif.gpio_out[31]) begin
                hi_len++;
            end else if (prev_g[31] && hi_len != P) begin
                bad_width++;
            end
            prev_g = lif.gpio_out;
        end
    end

    task automatic clear_model();
        @(posedge clk);
        mon_q.delete(); tab.delete();
        n_strobes = 0; bad_width = 0; field_chg = 0; lock_bad = 0;
        t_aph = 1'b0; t_dph = 1'b0; t_addr = 16'd0;
    endtask

    // Expected strobe order: address hi/lo, then hi/lo byte of each written word.
    function automatic bit seq_ok(input logic [15:0] base, input logic [15:0] w[$], input int nw, input bit has_addr);
        logic [15:0] e[$];
        if (has_addr) begin
            e.push_back({T_ADDR, base[15:8]});
            e.push_back({T_ADDR, base[7:0]});
        end
        for (int i = 0; i < nw; i++) begin
            e.push_back({T_DATA, w[i][15:8]});
            e.push_back({T_DATA, w[i][7:0]});
        end
        if (e.size() != mon_q.size()) return 1'b0;
        foreach (e[i]) if (e[i] !== mon_q[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit table_ok(input logic [15:0] base, input logic [15:0] w[$], input int nw);
        logic [15:0] a;
        if (tab.num() != nw) return 1'b0;
        for (int i = 0; i < nw; i++) begin
            a = base + 16'(i);
            if (!tab.exists(int'(a))) return 1'b0;
            if (tab[int'(a)] !== w[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Load scenario knobs and results
    int          cfg_valid_pct, cfg_gap_word, cfg_abort_strobe, cfg_restart_cyc;
    int          r_done_cnt, r_done_lat, r_gap_bad;
    logic        r_aborted;
    logic [16:0] r_ww;

    task automatic run_load(input logic [15:0] base, input logic [16:0] count, input logic [15:0] w[$]);
        int idx = 0, c = 0, gap_left = 0;
        bit gap_done = 0, abort_sent = 0, v;
        logic [31:0] gap_ref;
        clear_model();
        r_done_cnt = 0; r_done_lat = -1; r_gap_bad = 0; r_aborted = 1'b0; r_ww = 17'd0;
        @(negedge clk); #1;
        lif.cfg_base = base; lif.cfg_count = count; lif.cfg_start = 1'b1;
        while (c < 2000 && !(r_done_lat >= 0 && c >= r_done_lat + 4)) begin
            @(negedge clk); #1;
            c++;
            lif.cfg_start = 1'b0;
            lif.cfg_abort = 1'b0;
            if (lif.done) begin
                r_done_cnt++;
                if (r_done_lat < 0) r_done_lat = c;
                r_aborted = lif.aborted;
                r_ww      = lif.words_written;
            end
            if (c == cfg_restart_cyc) begin
                lif.cfg_base = base ^ 16'h5555; lif.cfg_count = count + 17'd3; lif.cfg_start = 1'b1;
            end
            if (cfg_abort_strobe > 0 && !abort_sent && n_strobes == cfg_abort_strobe && lif.gpio_out[31]) begin
                lif.cfg_abort = 1'b1; abort_sent = 1'b1;
            end
            if (!gap_done && idx == cfg_gap_word && (lif.word_ready || gap_left > 0)) begin
                if (gap_left == 0) begin gap_left = 10; gap_ref = lif.gpio_out; end
                if (!lif.word_ready || lif.gpio_out[31] || lif.gpio_out !== gap_ref) r_gap_bad++;
                gap_left--;
                if (gap_left == 0) gap_done = 1'b1;
                v = 1'b0;
            end else begin
                v = (idx < w.size()) && ($urandom_range(99, 0) < cfg_valid_pct);
            end
            lif.word_valid = v;
            lif.word_in    = v ? w[idx] : 16'($urandom);
            if (v && lif.word_ready) idx++;
        end
        lif.word_valid = 1'b0;
    endtask

    task automatic default_knobs();
        cfg_valid_pct = 100; cfg_gap_word = -1; cfg_abort_strobe = 0; cfg_restart_cyc = -1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (lif.gpio_out !== IDLE_G) begin n_fail++; $display("FAIL reset_gpio: got %h expected %h", lif.gpio_out, IDLE_G); end
        n_checks++; if ({lif.word_ready, lif.busy, lif.lut_locked, lif.done, lif.aborted} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b expected 00000", {lif.word_ready, lif.busy, lif.lut_locked, lif.done, lif.aborted}); end
        n_checks++; if (lif.words_written !== 17'd0) begin n_fail++; $display("FAIL reset_ww: got %0d expected 0", lif.words_written); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [15:0] w[$] = '{16'hABCD, 16'h0042};
        default_knobs();
        run_load(16'h1234, 17'd2, w);
        n_checks++; if (seq_ok(16'h1234, w, 2, 1'b1) !== 1'b1) begin n_fail++; $display("FAIL basic_seq: got %0d strobes expected 6 in order", mon_q.size()); end
        n_checks++; if (table_ok(16'h1234, w, 2) !== 1'b1) begin n_fail++; $display("FAIL basic_table: got %0d entries expected [1234]=abcd [1235]=0042", tab.num()); end
        n_checks++; if (r_done_cnt !== 1) begin n_fail++; $display("FAIL basic_done: got %0d pulses expected 1", r_done_cnt); end
        n_checks++; if (r_ww !== 17'd2 || r_aborted !== 1'b0) begin n_fail++; $display("FAIL basic_status: got ww=%0d ab=%b expected ww=2 ab=0", r_ww, r_aborted); end
        n_checks++; if (bad_width + field_chg + lock_bad !== 0) begin n_fail++; $display("FAIL basic_bus: got width=%0d fchg=%0d lock=%0d expected 0", bad_width, field_chg, lock_bad); end
        n_checks++; if (lif.words_written !== 17'd2) begin n_fail++; $display("FAIL basic_ww_hold: got %0d expected 2", lif.words_written); end
    endtask

    task automatic test_count_zero();
        logic [15:0] w[$];
        default_knobs();
        run_load(16'h0777, 17'd0, w);
        n_checks++; if (r_done_lat !== 2) begin n_fail++; $display("FAIL zero_latency: got %0d expected 2", r_done_lat); end
        n_checks++; if (n_strobes !== 0) begin n_fail++; $display("FAIL zero_strobes: got %0d expected 0", n_strobes); end
        n_checks++; if (r_done_cnt !== 1 || r_ww !== 17'd0 || r_aborted !== 1'b0) begin n_fail++; $display("FAIL zero_status: got done=%0d ww=%0d ab=%b expected 1/0/0", r_done_cnt, r_ww, r_aborted); end
    endtask

    task automatic test_gap();
        logic [15:0] w[$] = '{16'hABCD, 16'h0042};
        default_knobs();
        cfg_gap_word = 1;
        run_load(16'h1234, 17'd2, w);
        n_checks++; if (r_gap_bad !== 0) begin n_fail++; $display("FAIL gap_hold: got %0d bad cycles expected 0", r_gap_bad); end
        n_checks++; if (table_ok(16'h1234, w, 2) !== 1'b1 || seq_ok(16'h1234, w, 2, 1'b1) !== 1'b1) begin n_fail++; $display("FAIL gap_table: got %0d entries expected 2", tab.num()); end
        n_checks++; if (r_done_cnt !== 1 || r_ww !== 17'd2) begin n_fail++; $display("FAIL gap_status: got done=%0d ww=%0d expected 1/2", r_done_cnt, r_ww); end
    endtask

    task automatic test_abort();
        logic [15:0] w[$];
        for (int i = 0; i < 5; i++) w.push_back(16'($urandom));
        default_knobs();
        cfg_abort_strobe = 3;
        run_load(16'h4000, 17'd5, w);
        n_checks++; if (n_strobes !== 4) begin n_fail++; $display("FAIL abort_strobes: got %0d expected 4", n_strobes); end
        n_checks++; if (r_done_cnt !== 1 || r_aborted !== 1'b1 || r_ww !== 17'd1) begin n_fail++; $display("FAIL abort_status: got done=%0d ab=%b ww=%0d expected 1/1/1", r_done_cnt, r_aborted, r_ww); end
        n_checks++; if (seq_ok(16'h4000, w, 1, 1'b1) !== 1'b1 || table_ok(16'h4000, w, 1) !== 1'b1) begin n_fail++; $display("FAIL abort_seq: got %0d strobes expected addr pair plus one word", mon_q.size()); end
    endtask

    task automatic test_restart_ignored();
        logic [15:0] w[$] = '{16'h1111, 16'h2222, 16'h3333};
        default_knobs();
        cfg_restart_cyc = 6;
        run_load(16'h0A0B, 17'd3, w);
        n_checks++; if (seq_ok(16'h0A0B, w, 3, 1'b1) !== 1'b1 || table_ok(16'h0A0B, w, 3) !== 1'b1) begin n_fail++; $display("FAIL restart_seq: got %0d strobes expected 8 unchanged", mon_q.size()); end
        n_checks++; if (r_done_cnt !== 1 || r_ww !== 17'd3) begin n_fail++; $display("FAIL restart_status: got done=%0d ww=%0d expected 1/3", r_done_cnt, r_ww); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            logic [15:0] w[$];
            logic [15:0] base;
            int n;
            base = (it == 0) ? 16'hFFFE : 16'($urandom);
            n = $urandom_range(5, 1);
            for (int i = 0; i < n; i++) w.push_back(16'($urandom));
            default_knobs();
            cfg_valid_pct = $urandom_range(100, 30);
            run_load(base, 17'(n), w);
            n_checks++; if (seq_ok(base, w, n, 1'b1) !== 1'b1 || table_ok(base, w, n) !== 1'b1) begin n_fail++; $display("FAIL random_%0d_data: got %0d strobes expected %0d base %h", it, mon_q.size(), 2 + 2 * n, base); end
            n_checks++; if (r_done_cnt !== 1 || r_ww !== 17'(n) || r_aborted !== 1'b0) begin n_fail++; $display("FAIL random_%0d_status: got done=%0d ww=%0d ab=%b expected 1/%0d/0", it, r_done_cnt, r_ww, r_aborted, n); end
            n_checks++; if (bad_width + field_chg + lock_bad !== 0) begin n_fail++; $display("FAIL random_%0d_bus: got width=%0d fchg=%0d lock=%0d expected 0", it, bad_width, field_chg, lock_bad); end
        end
    endtask

    task automatic test_reset_midload();
        logic [15:0] w[$] = '{16'h5AA5};
        int c = 0;
        clear_model();
        @(negedge clk); #1;
        lif.cfg_base = 16'h0100; lif.cfg_count = 17'd1; lif.cfg_start = 1'b1;
        lif.word_valid = 1'b1; lif.word_in = 16'hDEAD;
        @(negedge clk); #1;
        lif.cfg_start = 1'b0;
        while (c < 200 && !(n_strobes == 3 && !lif.gpio_out[31])) begin
            @(negedge clk); #1; c++;
        end
        n_checks++; if (n_strobes !== 3) begin n_fail++; $display("FAIL midreset_reach: got %0d strobes expected 3", n_strobes); end
        rst = 1'b0;
        #1;
        n_checks++; if (lif.gpio_out !== IDLE_G || lif.busy !== 1'b0 || lif.lut_locked !== 1'b0) begin n_fail++; $display("FAIL midreset_idle: got gpio=%h busy=%b expected %h/0", lif.gpio_out, lif.busy, IDLE_G); end
        lif.word_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        default_knobs();
        run_load(16'h0200, 17'd1, w);
        n_checks++; if (seq_ok(16'h0200, w, 1, 1'b1) !== 1'b1 || table_ok(16'h0200, w, 1) !== 1'b1) begin n_fail++; $display("FAIL midreset_reload: got %0d strobes expected 4", mon_q.size()); end
        n_checks++; if (r_done_cnt !== 1 || r_ww !== 17'd1) begin n_fail++; $display("FAIL midreset_status: got done=%0d ww=%0d expected 1/1", r_done_cnt, r_ww); end
    endtask

    initial begin
        lif.cfg_start = 1'b0; lif.cfg_base = 16'd0; lif.cfg_count = 17'd0; lif.cfg_abort = 1'b0;
        lif.word_in = 16'd0; lif.word_valid = 1'b0;
        prev_g = IDLE_G; hi_len = 0;
        default_knobs();
        test_reset();
        test_basic();
        test_count_zero();
        test_gap();
        test_abort();
        test_restart_ignored();
        test_random();
        test_reset_midload();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lut_load_ctrl.md
Name: lut_load_ctrl

Overview:
Sequencer that loads one GPIO-programmed lookup table from a streamed block of 16-bit words. It turns a (base address, word count) command plus a valid/ready word stream into the table's GPIO write protocol: two address-byte writes, then two data-byte writes per word, with table-side auto-increment. It sits between the host-side loader (DMA/PS FIFO) and the shared 32-bit gpio_in bus of the table. It asserts lut_locked while loading so downstream logic gates lookups.

Parameters:
ADDR_REG, 0, GPIO register address of the table's address register
DATA_REG, 1, GPIO register address of the table's data register
IDLE_ADDR, 255, GPIO address field driven while idle; must decode to no register
PULSE_CYCLES, 4, cycles per bus phase (setup and strobe-high); legal range 1..255
W_CLK_BIT, 31, bit position of the write strobe in gpio_out
ADDR_LSB, 16, LSB of the 8-bit GPIO address field
DATA_LSB, 0, LSB of the 8-bit GPIO data field

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
cfg_start  in  1  one-cycle command strobe; sampled only in IDLE
cfg_base  in  16  first table address, latched on cfg_start
cfg_count  in  17  words to load, 0..65536, latched on cfg_start
cfg_abort  in  1  level; request early termination
word_in  in  16  table word
word_valid  in  1  word_in valid
word_ready  out  1  controller accepts word_in this cycle
gpio_out  out  32  drives the table's gpio_in; unused bits 0
busy  out  1  high from accepted cfg_start until done
lut_locked  out  1  equals busy
done  out  1  one-cycle pulse at end of command
aborted  out  1  valid with done; 1 if ended by cfg_abort
words_written  out  17  words fully written in current/last command

Behaviour:
- Reset (async, active-low): state IDLE; gpio_out = IDLE_ADDR in address field, strobe 0, data 0; word_ready, busy, lut_locked, done, aborted = 0; words_written = 0. Reset mid-load drops the bus to idle immediately; no partial pair is completed.
- States: IDLE, A_HI, A_LO, WAIT_WORD, D_HI, D_LO, TRAIL, DONE.
- Bus transaction (A_HI, A_LO, D_HI, D_LO): SETUP phase of PULSE_CYCLES cycles (address and data fields driven, strobe 0), then STROBE phase of PULSE_CYCLES cycles (same fields, strobe 1). Fields never change while the strobe is 1. Each transaction produces exactly one strobe rising edge.
- IDLE + cfg_start: latch base and count; busy=1; words_written=0. If count=0 go to DONE; otherwise go to A_HI. cfg_start while busy is ignored.
- A_HI sends ADDR_REG/base[15:8], then A_LO sends ADDR_REG/base[7:0], then go to WAIT_WORD.
- WAIT_WORD: word_ready=1, strobe 0, fields hold last values. On word_valid&word_ready, latch word_in and go to D_HI. Combinational ready is forbidden; ready is registered by state.
- D_HI sends DATA_REG/word[15:8]. D_LO sends DATA_REG/word[7:0].
- At end of D_LO: words_written+1. If words_written reaches count or abort is pending, go to TRAIL; otherwise go to WAIT_WORD.
- The controller never sends an address write between words; the table auto-increments.
- TRAIL: PULSE_CYCLES cycles with strobe 0 and fields held, so the table sees the strobe low. Then go to DONE.
- DONE: done=1 for one cycle; aborted valid; busy drops the same cycle; next state IDLE with gpio_out at idle values. words_written holds until the next cfg_start.
- Abort handling:
  - cfg_abort sampled in any busy state sets a pending flag.
  - In A_HI/A_LO: finish the current address write, then go to TRAIL.
  - In WAIT_WORD: go to TRAIL next cycle; no word is accepted.
  - In D_HI/D_LO: complete both data bytes of the current word first, so the table's byte-pair counter stays aligned.
- Wrap: addresses past 0xFFFF wrap in the table. With count=65536 all entries are written; the controller has no wrap logic.
- Per-word bus time is 4*PULSE_CYCLES cycles, excluding WAIT_WORD.

Test Plan:
- PULSE_CYCLES=2, base=0x1234, count=2, words 0xABCD and 0x0042 always valid -> strobed (addr,data) sequence (0,0x12),(0,0x34),(1,0xAB),(1,0xCD),(1,0x00),(1,0x42); each strobe high exactly 2 cycles; done pulse once; words_written=2; table model holds [0x1234]=0xABCD, [0x1235]=0x0042.
- count=0 -> done 2 cycles after cfg_start; no strobe edge ever; words_written=0; aborted=0.
- word_valid held low 10 cycles before 2nd word -> word_ready stays high, strobe stays 0, fields unchanged during the gap; final table contents identical to scenario 1.
- cfg_abort pulsed during the D_HI strobe of word 1 of count=5 -> D_LO still issued; done with aborted=1; words_written=1; exactly 4 strobes total.
- cfg_start re-pulsed mid-load with a different base -> ignored; original load completes unchanged.
- rst asserted during D_LO setup -> gpio_out idle (addr 255, strobe 0) in the same cycle, busy=0. After release, a new count=1 load completes correctly (table reset too).
